// File: rtl/scanout_sequencer.sv
// Frame scanout sequencer: turns a framebuffer pixel stream into Avalon-ST packets
// (one packet per frame) through a single output register, with frame-done and starvation tracking.
//
// state  | meaning
// IDLE   | waiting for cfg_enable with non-zero geometry
// ACTIVE | accepting pixels from the reader, x/y tracking frame position
// FLUSH  | last pixel accepted, waiting for the EOP beat to leave the output register
module scanout_sequencer #(
    parameter int W_BITS = 12,
    parameter int H_BITS = 12
) (
    input  logic              pixel_clock,
    input  logic              pixel_resetn,
    input  logic              cfg_enable,
    input  logic [W_BITS-1:0] cfg_width,
    input  logic [H_BITS-1:0] cfg_height,
    input  logic [29:0]       s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [29:0]       m_data,
    output logic              m_startofpacket,
    output logic              m_endofpacket,
    output logic              m_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       underflow_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W_BITS-1:0] w_q, w_d, x_q, x_d;
    logic [H_BITS-1:0] h_q, h_d, y_q, y_d;
    logic [29:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              done_q, done_d;
    logic [15:0]       uf_q, uf_d;

    logic src_xfer, snk_xfer, last_x, last_y;

    always_ff @(posedge pixel_clock) begin
        if (!pixel_resetn) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            uf_q    <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
            uf_q    <= uf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        h_d      = h_q;
        x_d      = x_q;
        y_d      = y_q;
        data_d   = data_q;
        valid_d  = valid_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        done_d   = 1'b0;
        uf_d     = uf_q;
        s_ready  = (state_q == ACTIVE) && (!valid_q || m_ready);
        src_xfer = s_valid && s_ready;
        snk_xfer = valid_q && m_ready;
        last_x   = (x_q == w_q - W_BITS'(1));
        last_y   = (y_q == h_q - H_BITS'(1));

        case (state_q)
            IDLE: begin
                if (cfg_enable && (cfg_width != '0) && (cfg_height != '0)) begin
                    state_d = ACTIVE;
                    w_d     = cfg_width;
                    h_d     = cfg_height;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ACTIVE: begin
                if (s_ready && !s_valid && (uf_q != 16'hFFFF)) begin
                    uf_d = uf_q + 16'd1;
                end
                if (src_xfer) begin
                    if (last_x) begin
                        x_d = '0;
                        if (last_y) begin
                            y_d     = '0;
                            state_d = FLUSH;
                        end else begin
                            y_d = y_q + H_BITS'(1);
                        end
                    end else begin
                        x_d = x_q + W_BITS'(1);
                    end
                end
            end
            FLUSH: begin
                if (snk_xfer && eop_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new pixel may replace a beat in the same cycle it leaves, so the load wins over the clear.
        if (src_xfer) begin
            data_d  = s_data;
            valid_d = 1'b1;
            sop_d   = (x_q == '0) && (y_q == '0);
            eop_d   = last_x && last_y;
        end else if (snk_xfer) begin
            valid_d = 1'b0;
        end
    end

    assign m_data          = data_q;
    assign m_valid         = valid_q;
    assign m_startofpacket = sop_q;
    assign m_endofpacket   = eop_q;
    assign m_empty         = 1'b0;
    assign busy            = (state_q != IDLE);
    assign frame_done      = done_q;
    assign underflow_cnt   = uf_q;

endmodule

// File: tb/tb_scanout_sequencer.sv
// Self-checking bench for scanout_sequencer: table of frame scenarios checked beat by beat,
// plus directed sequences for zero geometry and reset in the middle of a frame.
module tb_scanout_sequencer;

    localparam int WB = 12;
    localparam int HB = 12;

    logic          pixel_clock = 1'b0;
    logic          pixel_resetn = 1'b0;
    logic          cfg_enable = 1'b0;
    logic [WB-1:0] cfg_width = '0;
    logic [HB-1:0] cfg_height = '0;
    logic [29:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [29:0]   m_data;
    logic          m_startofpacket, m_endofpacket, m_empty, m_valid;
    logic          m_ready = 1'b0;
    logic          busy, frame_done;
    logic [15:0]   underflow_cnt;

    scanout_sequencer #(.W_BITS(WB), .H_BITS(HB)) dut (
        .pixel_clock(pixel_clock),
        .pixel_resetn(pixel_resetn),
        .cfg_enable(cfg_enable),
        .cfg_width(cfg_width),
        .cfg_height(cfg_height),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_data(m_data),
        .m_startofpacket(m_startofpacket),
        .m_endofpacket(m_endofpacket),
        .m_empty(m_empty),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .busy(busy),
        .frame_done(frame_done),
        .underflow_cnt(underflow_cnt)
    );

    always #5 pixel_clock = ~pixel_clock;

    typedef struct {
        int w;
        int h;
        int mr_toggle;
        int gap_at;
        int gap_len;
        int drop_after;
        int nfr;
        int exp_uf;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   failures = 0;
    int   exp_uf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] pat(input int vi, input int k);
        return 30'(vi * 4096 + k * 3 + 1);
    endfunction

    // Starts at #1 after a rising edge with the DUT idle; returns the same way.
    task automatic run_vec(input vec_t v, input int vi);
        int n, src, snk, fd, cyc, last_eop_cyc, prev_beat_cyc, gap_left;
        bit stream, stalled, done;
        logic [29:0] hd;
        logic hs, he;
        n = v.w * v.h;
        stream = (v.mr_toggle == 0) && (v.gap_len == 0);
        src = 0; snk = 0; fd = 0; cyc = 0; gap_left = v.gap_len;
        last_eop_cyc = -100; prev_beat_cyc = -100;
        stalled = 1'b0; done = 1'b0; hd = '0; hs = 1'b0; he = 1'b0;
        cfg_width  = WB'(v.w);
        cfg_height = HB'(v.h);
        cfg_enable = 1'b1;
        while (!done && cyc < 600) begin
            if (frame_done && (fd + 1 >= v.nfr)) cfg_enable = 1'b0;
            if (v.drop_after >= 0 && snk >= v.drop_after) cfg_enable = 1'b0;
            m_ready = (v.mr_toggle != 0) ? ((cyc % 2) == 0) : 1'b1;
            if (v.gap_len > 0 && src == v.gap_at && gap_left > 0) begin
                s_valid = 1'b0;
                gap_left--;
            end else begin
                s_valid = 1'b1;
            end
            s_data = pat(vi, src);
            @(negedge pixel_clock);
            if (stalled) begin
                chk("stall_valid", 32'(m_valid), 1);
                chk("stall_data", 32'(m_data), 32'(hd));
                chk("stall_sop", 32'(m_startofpacket), 32'(hs));
                chk("stall_eop", 32'(m_endofpacket), 32'(he));
            end
            if (m_valid && m_ready) begin
                chk("beat_data", 32'(m_data), 32'(pat(vi, snk)));
                chk("beat_sop", 32'(m_startofpacket), 32'((snk % n) == 0));
                chk("beat_eop", 32'(m_endofpacket), 32'((snk % n) == n - 1));
                chk("m_empty", 32'(m_empty), 0);
                if ((snk % n) != 0 && stream) chk("beat_spacing", cyc - prev_beat_cyc, 1);
                if ((snk % n) == 0 && snk > 0) chk("interframe_gap_ge2", 32'((cyc - prev_beat_cyc) >= 2), 1);
                if ((snk % n) == n - 1) last_eop_cyc = cyc;
                prev_beat_cyc = cyc;
                snk++;
            end
            stalled = m_valid && !m_ready;
            hd = m_data; hs = m_startofpacket; he = m_endofpacket;
            if (s_valid && s_ready) src++;
            if (frame_done) begin
                chk("frame_done_timing", cyc, last_eop_cyc + 1);
                fd++;
                if (fd >= v.nfr) done = 1'b1;
            end
            @(posedge pixel_clock); #1;
            cyc++;
        end
        chk("frame_done_seen", 32'(done), 1);
        chk("beat_count", snk, n * v.nfr);
        exp_uf = exp_uf + v.exp_uf;
        chk("underflow_cnt", 32'(underflow_cnt), exp_uf);
        cfg_enable = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge pixel_clock);
            chk("tail_idle", {30'd0, busy, m_valid}, 0);
            @(posedge pixel_clock); #1;
        end
    endtask

    task automatic zero_geometry(input int w, input int h);
        cfg_width  = WB'(w);
        cfg_height = HB'(h);
        cfg_enable = 1'b1;
        s_valid    = 1'b1;
        m_ready    = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge pixel_clock);
            chk("zero_geom_idle", {29'd0, busy, m_valid, s_ready}, 0);
            @(posedge pixel_clock); #1;
        end
        cfg_enable = 1'b0;
    endtask

    task automatic reset_mid_frame();
        int src, snk, cyc;
        vec_t rv;
        src = 0; snk = 0; cyc = 0;
        cfg_width = 4; cfg_height = 2; cfg_enable = 1'b1;
        s_valid = 1'b1; m_ready = 1'b1;
        while (snk < 6 && cyc < 100) begin
            s_data = pat(9, src);
            @(negedge pixel_clock);
            if (m_valid && m_ready) snk++;
            if (s_valid && s_ready) src++;
            @(posedge pixel_clock); #1;
            cyc++;
        end
        chk("rst_reached_beat5", snk, 6);
        pixel_resetn = 1'b0;
        @(posedge pixel_clock); #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underflow", 32'(underflow_cnt), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        exp_uf = 0;
        pixel_resetn = 1'b1;
        rv = '{4, 2, 0, -1, 0, -1, 1, 0};
        run_vec(rv, 10);
    endtask

    initial begin
        vecs[0] = '{4, 2, 0, -1, 0, -1, 2, 0};
        vecs[1] = '{4, 2, 1, -1, 0, -1, 1, 0};
        vecs[2] = '{3, 1, 0,  1, 5, -1, 1, 5};
        vecs[3] = '{4, 2, 0, -1, 0,  2, 1, 0};
        vecs[4] = '{1, 1, 0, -1, 0, -1, 1, 0};
        vecs[5] = '{5, 3, 1, -1, 0, -1, 1, 0};
        vecs[6] = '{1, 1, 0, -1, 0, -1, 2, 0};

        pixel_resetn = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(posedge pixel_clock);
        #1;
        chk("reset_m_valid", 32'(m_valid), 0);
        chk("reset_m_data", 32'(m_data), 0);
        chk("reset_sop_eop", {30'd0, m_startofpacket, m_endofpacket}, 0);
        chk("reset_s_ready", 32'(s_ready), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        chk("reset_underflow", 32'(underflow_cnt), 0);
        pixel_resetn = 1'b1;
        @(posedge pixel_clock); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
        zero_geometry(0, 5);
        zero_geometry(5, 0);
        reset_mid_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scanout_sequencer.md
SCANOUT_SEQUENCER -- requirements
Module: scanout_sequencer

Interface
REQ-001 SHALL have parameter W_BITS, default 12: frame width counter/config width.
REQ-002 SHALL have parameter H_BITS, default 12: frame height counter/config width.
REQ-003 SHALL use one clock; reset is synchronous and active-low: pixel_clock  in  1  sole clock, all logic on rising edge.
REQ-004 pixel_resetn  in  1  synchronous active-low reset.
REQ-005 cfg_enable  in  1  scanout enable, already synchronous to pixel_clock.
REQ-006 cfg_width  in  W_BITS  pixels per line.
REQ-007 cfg_height  in  H_BITS  lines per frame.
REQ-008 s_data  in  30  pixel from framebuffer reader, 10-bit R,G,B.
REQ-009 s_valid  in  1  s_data valid.
REQ-010 s_ready  out  1  sequencer accepts s_data this cycle.
REQ-011 m_data  out  30  Avalon-ST pixel data.
REQ-012 m_startofpacket  out  1  first pixel of frame.
REQ-013 m_endofpacket  out  1  last pixel of frame.
REQ-014 m_empty  out  1  always 0.
REQ-015 m_valid  out  1  output beat valid.
REQ-016 m_ready  in  1  sink ready, readyLatency 0.
REQ-017 busy  out  1  state != IDLE.
REQ-018 frame_done  out  1  one-cycle pulse at frame completion (irq source).
REQ-019 underflow_cnt  out  16  saturating starvation-cycle count.

Function
REQ-020 States IDLE, ACTIVE, FLUSH; transfer on source = s_valid&&s_ready; transfer on sink = m_valid&&m_ready.
REQ-021 IDLE->ACTIVE when cfg_enable=1, cfg_width!=0, cfg_height!=0; width/height latched that cycle, x=0, y=0; config changes ignored until next IDLE.
REQ-022 cfg_enable=1 with zero width or height: remain IDLE, no beats.
REQ-023 Single output register: s_ready = (state==ACTIVE) && (!m_valid || m_ready); s_ready=0 in IDLE and FLUSH.
REQ-024 Source transfer loads m_data<=s_data, m_valid<=1, SOP<=(x==0&&y==0), EOP<=(x==w-1&&y==h-1) next edge; latency 1 cycle.
REQ-025 Sink transfer without simultaneous source transfer clears m_valid; m_data/SOP/EOP held stable while m_valid&&!m_ready.
REQ-026 x increments per source transfer; at w-1 wraps to 0 and y increments; at last pixel ACTIVE->FLUSH.
REQ-027 FLUSH: on sink transfer of EOP beat -> IDLE, frame_done=1 next cycle for exactly one cycle.
REQ-028 cfg_enable deassert mid-frame: current frame completes in full; next frame starts only if cfg_enable=1 in IDLE.
REQ-029 Back-to-back frames: minimum one IDLE cycle between EOP sink transfer and next SOP source transfer.
REQ-030 underflow_cnt increments each cycle state==ACTIVE && s_ready && !s_valid; saturates at 0xFFFF; cleared only by reset.
REQ-031 m_empty tied 0; SOP/EOP qualified only with m_valid.
REQ-032 1x1 frame: single beat carries SOP=1 and EOP=1.

Reset
REQ-033 pixel_resetn=0 sampled: state IDLE, x=y=0, m_valid=0, m_data=0, SOP=0, EOP=0, s_ready=0, busy=0, frame_done=0, underflow_cnt=0.
REQ-034 Reset mid-frame aborts without EOP; m_valid low the cycle after reset sampled.

Verification
REQ-035 w=4,h=2, s_valid=1, m_ready=1, enable=1 -> 8 beats consecutive, SOP beat 0 only, EOP beat 7 only, frame_done one cycle after beat 7, next SOP ≥2 cycles after beat 7.
REQ-036 w=4,h=2, m_ready toggling 1,0 -> m_data/SOP/EOP stable while stalled, exactly 8 beats in order, no loss or duplicate.
REQ-037 w=3,h=1, s_valid low 5 cycles mid-line -> m_valid gaps, underflow_cnt=5, frame still 3 beats with EOP last.
REQ-038 enable dropped after beat 2 of 4x2 frame -> all 8 beats emitted, frame_done pulses, then busy=0 and no further SOP.
REQ-039 w=1,h=1 -> one beat with SOP=1,EOP=1; w=0,h=5 with enable=1 -> busy stays 0, no m_valid.
REQ-040 reset asserted at beat 5 of 4x2 -> next cycle m_valid=0, busy=0, underflow_cnt=0; after release new frame starts with SOP.
